// File: rtl/mem_stage_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate cache for the MEM stage.
// Optional read hit/miss counters are built only when CACHE_STATS_EN is defined.
module mem_stage_cache_ctrl #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_en,
  input  logic        MEM_W_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR, RESP} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  // RESP serves the latched request, so the result never depends on addr during the stall
  logic [31:0]        look_addr;
  logic [INDEX_W-1:0] look_idx, fill_idx;
  logic [TAG_W-1:0]   look_tag, fill_tag;
  logic               hit, fill_hit, rd_req;

  assign look_addr = (state == RESP) ? mem_addr : addr;
  assign look_idx  = look_addr[INDEX_W+1:2];
  assign look_tag  = look_addr[31:INDEX_W+2];
  assign fill_idx  = mem_addr[INDEX_W+1:2];
  assign fill_tag  = mem_addr[31:INDEX_W+2];
  assign hit       = valid[look_idx] && (tag_mem[look_idx] == look_tag);
  assign fill_hit  = valid[fill_idx] && (tag_mem[fill_idx] == fill_tag);
  assign rd_req    = MEM_R_en && !MEM_W_en;

  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:    ready = !MEM_W_en && !(MEM_R_en && !hit);
      RESP:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rdata   = (MEM_R_en && ready) ? data_mem[look_idx] : 32'd0;
  assign mem_req = (state == RD_MISS) || (state == WR);
  assign mem_we  = (state == WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MEM_W_en) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            state     <= WR;
          end else if (MEM_R_en && !hit) begin
            mem_addr <= addr;
            state    <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            valid[fill_idx] <= 1'b1;
            state           <= RESP;
          end
        end
        WR:      if (mem_ack) state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it
  always_ff @(posedge clk) begin
    if (!rst && mem_ack) begin
      if (state == RD_MISS) begin
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= mem_rdata;
      end else if (state == WR && fill_hit) begin
        data_mem[fill_idx] <= mem_wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hits, misses;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits   <= '0;
      misses <= '0;
    end else if (state == IDLE && rd_req) begin
      if (hit && hits != 16'hFFFF)    hits   <= hits + 16'd1;
      if (!hit && misses != 16'hFFFF) misses <= misses + 16'd1;
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

  logic unused_bits;
  assign unused_bits = ^{look_addr[1:0], rd_req};
endmodule

// File: tb/tb_mem_stage_cache_ctrl.sv
// Self-checking bench for mem_stage_cache_ctrl: directed test-plan steps then random traffic
// checked against a line-table / backing-memory reference model.
module tb_mem_stage_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_en, MEM_W_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count, miss_count;

  mem_stage_cache_ctrl #(.INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: 64 lines of {valid, tag, word} plus a sparse backing memory
  logic [31:0] bmem [logic [31:0]];
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  int          m_hits, m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input int n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic chk_counts(input string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"}, {16'd0, hit_count}, {16'd0, sat(m_hits)});
    chk({tag, "_miss"}, {16'd0, miss_count}, {16'd0, sat(m_miss)});
`else
    chk({tag, "_hits"}, {16'd0, hit_count}, 32'd0);
    chk({tag, "_miss"}, {16'd0, miss_count}, 32'd0);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  // Waits dly stall cycles with mem_req held, then pulses ack; returns in the RESP cycle (negedge)
  task automatic serve(input int dly, input logic [31:0] rd);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("req_hold", {31'd0, mem_req}, 32'd1);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = rd;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    chk("resp_ready", {31'd0, ready}, 32'd1);
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic do_read(input logic [31:0] a, input int dly);
    int idx;
    logic [31:0] v;
    idx = int'(a[7:2]);
    MEM_R_en = 1'b1;
    MEM_W_en = 1'b0;
    addr = a;
    @(negedge clk);
    if (m_valid[idx] && m_tag[idx] == a[31:8]) begin
      m_hits++;
      chk("hit_ready", {31'd0, ready}, 32'd1);
      chk("hit_rdata", rdata, m_data[idx]);
      chk("hit_noreq", {31'd0, mem_req}, 32'd0);
    end else begin
      m_miss++;
      chk("miss_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("miss_req", {31'd0, mem_req}, 32'd1);
      chk("miss_we", {31'd0, mem_we}, 32'd0);
      chk("miss_addr", mem_addr, a);
      if (!bmem.exists(a)) bmem[a] = $urandom;
      v = bmem[a];
      serve(dly, v);
      chk("miss_rdata", rdata, v);
      m_valid[idx] = 1'b1;
      m_tag[idx] = a[31:8];
      m_data[idx] = v;
    end
    @(posedge clk); #1;
    MEM_R_en = 1'b0;
    chk_counts("rd");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int dly, input bit both);
    int idx;
    idx = int'(a[7:2]);
    MEM_W_en = 1'b1;
    MEM_R_en = both;
    addr = a;
    wdata = d;
    @(negedge clk);
    chk("wr_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    wdata = $urandom;
    @(negedge clk);
    chk("wr_req", {31'd0, mem_req}, 32'd1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", mem_addr, a);
    chk("wr_wdata", mem_wdata, d);
    serve(dly, $urandom);
    bmem[a] = d;
    if (m_valid[idx] && m_tag[idx] == a[31:8]) m_data[idx] = d;
    @(posedge clk); #1;
    MEM_W_en = 1'b0;
    MEM_R_en = 1'b0;
    chk_counts("wr");
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    MEM_R_en = 1'b0;
    MEM_W_en = 1'b0;
    addr = '0;
    wdata = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    chk_counts("rst");
    @(posedge clk); #1;

    bmem[32'h100] = 32'hDEADBEEF;
    do_read(32'h100, 3);
    do_read(32'h100, 0);
    do_write(32'h100, 32'h12345678, 0, 1'b0);
    do_read(32'h100, 0);
    do_read(32'h200, 1);
    do_read(32'h100, 2);
    do_write(32'h300, 32'hCAFEF00D, 1, 1'b0);
    do_read(32'h300, 0);
    do_read(32'h300, 0);

    // Reset in the second RD_MISS cycle, then a stray ack
    MEM_R_en = 1'b1;
    addr = 32'h400;
    @(negedge clk);
    chk("rm_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    MEM_R_en = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rm_req", {31'd0, mem_req}, 32'd0);
    chk("rm_ready_idle", {31'd0, ready}, 32'd1);
    chk_counts("rm");
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    do_read(32'h400, 0);
    do_read(32'h100, 1);

    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 3) == 0)
        do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      else
        do_read(a, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
